// File: rtl/mem_access_unit_pkg.sv
// Shared access-mode definitions for the MEM-stage load/store path.
package mem_access_unit_pkg;

  localparam int unsigned MMD_W = 3;

  typedef logic [MMD_W-1:0] mmd_t;

  localparam mmd_t MMD_LB  = 3'b000;
  localparam mmd_t MMD_LBU = 3'b001;
  localparam mmd_t MMD_LH  = 3'b010;
  localparam mmd_t MMD_LHU = 3'b011;
  localparam mmd_t MMD_LW  = 3'b100;

  // Encodings above LW are reserved and must fault.
  function automatic logic mmd_legal(input mmd_t m);
    return (m <= MMD_LW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: store enables/replication,
// load lane selection with extension, and alignment checking.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic        aligned,
  output logic        mode_ok,
  input  logic [2:0]  ld_mode,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] rext
);

  // Store side: byte enables, data replication and alignment for the
  // access being presented.
  always_comb begin
    be      = '0;
    wrep    = '0;
    aligned = 1'b0;
    mode_ok = mmd_legal(mode);
    case (mode)
      MMD_LB, MMD_LBU: begin
        be      = 4'b0001 << off;
        wrep    = {4{wdata[7:0]}};
        aligned = 1'b1;
      end
      MMD_LH, MMD_LHU: begin
        be      = off[1] ? 4'b1100 : 4'b0011;
        wrep    = {2{wdata[15:0]}};
        aligned = ~off[0];
      end
      MMD_LW: begin
        be      = 4'b1111;
        wrep    = wdata;
        aligned = (off == 2'b00);
      end
      default: begin
        be      = '0;
        wrep    = '0;
        aligned = 1'b0;
      end
    endcase
  end

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Load side: pick the addressed lane of the returned word and extend it.
  always_comb begin
    rbyte = '0;
    rhalf = '0;
    rext  = '0;
    case (ld_off)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_mode)
      MMD_LB:  rext = {{24{rbyte[7]}}, rbyte};
      MMD_LBU: rext = {24'h0, rbyte};
      MMD_LH:  rext = {{16{rhalf[15]}}, rhalf};
      MMD_LHU: rext = {16'h0, rhalf};
      MMD_LW:  rext = rdata;
      default: rext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: runs one req/ack bus transaction per
// access, stalls the pipeline while it is outstanding, and reports faults.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        memMemRead,
  input  logic        memMemWrite,
  input  logic [2:0]  memMemMode,
  input  logic [31:0] memALUOut,
  input  logic [31:0] memWriteToMemData,
  output logic        memStall,
  output logic [31:0] memReadData,
  output logic        memFault,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  output logic [3:0]  busBe,
  input  logic        busAck,
  input  logic [31:0] busRData,
  input  logic        busErr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [2:0]  ld_mode;
  logic [1:0]  ld_off;
  logic        ld_is_load;

  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] rext;
  logic        aligned;
  logic        mode_ok;
  logic        access;
  logic        legal;

  // Mode and lane offset are captured at issue so load extraction does not
  // depend on the stage register staying put through the ack edge.
  mem_lane_align u_align (
    .mode    (memMemMode),
    .off     (memALUOut[1:0]),
    .wdata   (memWriteToMemData),
    .be      (be),
    .wrep    (wrep),
    .aligned (aligned),
    .mode_ok (mode_ok),
    .ld_mode (ld_mode),
    .ld_off  (ld_off),
    .rdata   (busRData),
    .rext    (rext)
  );

  assign access   = memMemRead | memMemWrite;
  assign legal    = ~(memMemRead & memMemWrite) & mode_ok & aligned;
  assign memStall = ((state == S_IDLE) & access) | (state == S_WAIT);

  // Transaction FSM with registered bus outputs and result/fault flags.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ld_mode     <= '0;
      ld_off      <= '0;
      ld_is_load  <= 1'b0;
      busReq      <= 1'b0;
      busWe       <= 1'b0;
      busAddr     <= '0;
      busWData    <= '0;
      busBe       <= '0;
      memReadData <= '0;
      memFault    <= 1'b0;
    end else begin
      memFault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (legal) begin
              state      <= S_WAIT;
              busReq     <= 1'b1;
              busWe      <= memMemWrite;
              busAddr    <= {memALUOut[31:2], 2'b00};
              busWData   <= wrep;
              busBe      <= be;
              cnt        <= '0;
              ld_mode    <= memMemMode;
              ld_off     <= memALUOut[1:0];
              ld_is_load <= memMemRead;
            end else begin
              state       <= S_FAULT;
              memFault    <= 1'b1;
              memReadData <= '0;
            end
          end
        end
        S_WAIT: begin
          if (busErr || (!busAck && cnt == TO_LAST)) begin
            state       <= S_FAULT;
            busReq      <= 1'b0;
            memFault    <= 1'b1;
            memReadData <= '0;
          end else if (busAck) begin
            state  <= S_DONE;
            busReq <= 1'b0;
            if (ld_is_load) begin
              memReadData <= rext;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a lane-level
// reference model.
module tb_mem_access_unit;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        memMemRead, memMemWrite;
  logic [2:0]  memMemMode;
  logic [31:0] memALUOut, memWriteToMemData;
  logic        memStall, memFault;
  logic [31:0] memReadData;
  logic        busReq, busWe;
  logic [31:0] busAddr, busWData;
  logic [3:0]  busBe;
  logic        busAck, busErr;
  logic [31:0] busRData;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] model_rd = '0;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .rstN              (rstN),
    .memMemRead        (memMemRead),
    .memMemWrite       (memMemWrite),
    .memMemMode        (memMemMode),
    .memALUOut         (memALUOut),
    .memWriteToMemData (memWriteToMemData),
    .memStall          (memStall),
    .memReadData       (memReadData),
    .memFault          (memFault),
    .busReq            (busReq),
    .busWe             (busWe),
    .busAddr           (busAddr),
    .busWData          (busWData),
    .busBe             (busBe),
    .busAck            (busAck),
    .busRData          (busRData),
    .busErr            (busErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] mode, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (mode)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return b;
      3'd2:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd3:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] mode, input logic [1:0] off);
    if (mode <= 3'd1) return 4'(1 << off);
    if (mode <= 3'd3) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] mode, input logic [31:0] w);
    if (mode <= 3'd1) return (w & 32'hFF) * 32'h01010101;
    if (mode <= 3'd3) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic ref_legal(input logic rd, input logic wr, input logic [2:0] mode,
                                     input logic [1:0] off);
    if (rd && wr) return 1'b0;
    if (mode > 3'd4) return 1'b0;
    if (mode >= 3'd2 && mode <= 3'd3 && off[0]) return 1'b0;
    if (mode == 3'd4 && off != 2'd0) return 1'b0;
    return 1'b1;
  endfunction

  // One access: d = WAIT cycles before the bus responds (d >= T means never).
  task automatic xact(input logic rd, input logic wr, input logic [2:0] mode,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rdat, input int unsigned d, input logic err);
    logic        legal;
    logic        resp;
    int unsigned stalls, reqs, i;
    legal = ref_legal(rd, wr, mode, addr[1:0]);
    memMemRead = rd;  memMemWrite = wr;  memMemMode = mode;
    memALUOut = addr; memWriteToMemData = wd;
    #1;
    chk("stall_cycle0", 32'(memStall), 32'd1);
    tick();
    if (!legal) begin
      chk("illegal_fault", 32'(memFault), 32'd1);
      chk("illegal_rdata", memReadData, 32'd0);
      chk("illegal_noreq", 32'(busReq), 32'd0);
      chk("illegal_stall", 32'(memStall), 32'd0);
      model_rd = '0;
    end else begin
      chk("busWe", 32'(busWe), 32'(wr));
      chk("busAddr", busAddr, addr & 32'hFFFF_FFFC);
      if (wr) begin
        chk("busBe", 32'(busBe), 32'(ref_be(mode, addr[1:0])));
        chk("busWData", busWData, ref_wdata(mode, wd));
      end
      stalls = 1; reqs = 0; resp = 1'b0; i = 0;
      while (i < T) begin
        stalls += 32'(memStall);
        reqs   += 32'(busReq);
        if (i == d) begin
          busRData = rdat;
          if (err) busErr = 1'b1; else busAck = 1'b1;
          tick();
          busAck = 1'b0; busErr = 1'b0; busRData = $urandom;
          resp = 1'b1;
          break;
        end
        busRData = $urandom;
        tick();
        i++;
      end
      memMemRead = 1'b0; memMemWrite = 1'b0;
      chk("stall_cycles", stalls, resp ? d + 2 : T + 1);
      chk("req_cycles", reqs, resp ? d + 1 : T);
      chk("req_dropped", 32'(busReq), 32'd0);
      chk("stall_end", 32'(memStall), 32'd0);
      if (resp && !err) begin
        if (rd) model_rd = ref_load(mode, addr[1:0], rdat);
        chk("done_nofault", 32'(memFault), 32'd0);
      end else begin
        model_rd = '0;
        chk("fault_pulse", 32'(memFault), 32'd1);
      end
      chk("readdata", memReadData, model_rd);
    end
    memMemRead = 1'b0; memMemWrite = 1'b0;
    tick();
    chk("idle_nofault", 32'(memFault), 32'd0);
    chk("idle_noreq", 32'(busReq), 32'd0);
  endtask

  initial begin
    logic        rd, wr;
    logic [2:0]  mode;
    logic [31:0] addr;
    rstN = 1'b0;
    memMemRead = 1'b0; memMemWrite = 1'b0; memMemMode = '0;
    memALUOut = '0; memWriteToMemData = '0;
    busAck = 1'b0; busErr = 1'b0; busRData = '0;
    tick(); tick();
    rstN = 1'b1;
    chk("rst_busReq", 32'(busReq), 32'd0);
    chk("rst_rdata", memReadData, 32'd0);
    chk("rst_fault", 32'(memFault), 32'd0);
    chk("rst_stall", 32'(memStall), 32'd0);
    chk("rst_busBe", 32'(busBe), 32'd0);

    // Directed cases
    xact(1, 0, 3'd4, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    chk("lw_value", memReadData, 32'hDEADBEEF);
    xact(1, 0, 3'd0, 32'h103, 32'h0, 32'h80112233, 1, 0);
    chk("lb_value", memReadData, 32'hFFFFFF80);
    xact(1, 0, 3'd1, 32'h103, 32'h0, 32'h80112233, 0, 0);
    chk("lbu_value", memReadData, 32'h00000080);
    xact(1, 0, 3'd3, 32'h102, 32'h0, 32'h80112233, 2, 0);
    chk("lhu_value", memReadData, 32'h00008011);
    xact(0, 1, 3'd2, 32'h102, 32'h0000ABCD, 32'h0, 0, 0);
    chk("sh_keeps_rdata", memReadData, 32'h00008011);
    xact(1, 0, 3'd4, 32'h101, 32'h0, 32'h0, 0, 0);
    xact(1, 0, 3'd5, 32'h100, 32'h0, 32'h0, 0, 0);
    xact(1, 1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 0);
    xact(1, 0, 3'd4, 32'h200, 32'h0, 32'h12345678, 0, 0);
    xact(1, 0, 3'd4, 32'h200, 32'h0, 32'h0, 10, 0);
    xact(0, 1, 3'd0, 32'h201, 32'h5A, 32'h0, 2, 1);

    // Ack with nothing outstanding must be ignored.
    busAck = 1'b1; busRData = 32'hCAFEF00D;
    tick();
    busAck = 1'b0;
    chk("stray_ack_rdata", memReadData, model_rd);
    chk("stray_ack_noreq", 32'(busReq), 32'd0);
    chk("stray_ack_fault", 32'(memFault), 32'd0);

    // Reset while a load is in WAIT.
    memMemRead = 1'b1; memMemMode = 3'd4; memALUOut = 32'h300;
    tick();
    chk("pre_rst_req", 32'(busReq), 32'd1);
    rstN = 1'b0;
    memMemRead = 1'b0;
    #1;
    chk("async_rst_req", 32'(busReq), 32'd0);
    chk("async_rst_addr", busAddr, 32'd0);
    chk("async_rst_we", 32'(busWe), 32'd0);
    chk("async_rst_wdata", busWData, 32'd0);
    chk("async_rst_rdata", memReadData, 32'd0);
    chk("async_rst_stall", 32'(memStall), 32'd0);
    model_rd = '0;
    #1;
    rstN = 1'b1;
    tick();
    xact(1, 0, 3'd4, 32'h304, 32'h0, 32'hA5A5_0F0F, 1, 0);
    chk("post_rst_lw", memReadData, 32'hA5A5_0F0F);

    // Randomized accesses
    for (int k = 0; k < 60; k++) begin
      rd   = ($urandom_range(0, 1) == 1);
      wr   = !rd;
      if ($urandom_range(0, 15) == 0) begin rd = 1'b1; wr = 1'b1; end
      mode = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (mode == 3'd4) addr[1:0] = 2'b00;
        if (mode == 3'd2 || mode == 3'd3) addr[0] = 1'b0;
      end
      xact(rd, wr, mode, addr, $urandom, $urandom,
           $urandom_range(0, T + 1), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
